// File: rtl/apb_lin_pkg.sv
// Shared decode constants, region codes and FSM encoding for the APB linear memory bridge.
package apb_lin_pkg;

    typedef enum logic [1:0] {
        RegionReg  = 2'b00,
        RegionTx   = 2'b01,
        RegionRx   = 2'b10,
        RegionNone = 2'b11
    } region_e;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRdWait = 2'b01,
        StResp   = 2'b10
    } state_e;

    localparam int unsigned RegionLsb    = 6;
    localparam logic [1:0]  AlignMask    = 2'b11;
    localparam int unsigned MinRdLatency = 1;
    localparam int unsigned MaxRdLatency = 4;

    // TX is write-only, RX is read-only, the top region is unmapped.
    function automatic logic dir_error(input logic [1:0] region, input logic write);
        return (region == RegionNone) ||
               (region == RegionTx && !write) ||
               (region == RegionRx && write);
    endfunction

endpackage

// File: rtl/apb_lin_addr_decode.sv
// Combinational APB address decode: target region, word index and access error.
module apb_lin_addr_decode
    import apb_lin_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned MEM_AW     = 4,
    parameter int unsigned REG_COUNT  = 11
) (
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic                  pwrite,
    output logic [1:0]            region,
    output logic [MEM_AW-1:0]     index,
    output logic                  error
);

    if (ADDR_WIDTH < 8 || ADDR_WIDTH < MEM_AW + 2) begin : gen_bad_addr_width
        $error("apb_lin_addr_decode: ADDR_WIDTH too small for the decode map");
    end

    // Upper address bits are aliased, not decoded.
    if (ADDR_WIDTH > 8) begin : gen_unused_upper
        logic unused_paddr_hi;
        assign unused_paddr_hi = ^paddr[ADDR_WIDTH-1:8];
    end

    logic misaligned;
    logic index_oob;

    always_comb begin
        region     = paddr[RegionLsb +: 2];
        index      = paddr[MEM_AW+1:2];
        misaligned = (paddr[1:0] & AlignMask) != 2'b00;
        index_oob  = (region == RegionReg) && (32'(index) >= REG_COUNT);
        error      = dir_error(region, pwrite) || misaligned || index_oob;
    end

endmodule

// File: rtl/apb_lin_mem_bridge.sv
// APB slave bridging onto a register file, a write-only TX memory and a read-only RX memory.
module apb_lin_mem_bridge
    import apb_lin_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_AW     = 4,
    parameter int unsigned REG_COUNT  = 11,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                    pclk,
    input  logic                    preset_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    input  logic [DATA_WIDTH/8-1:0] pstrb_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    output logic                    reg_we,
    output logic                    reg_re,
    output logic [MEM_AW-1:0]       reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_be,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    output logic                    tx_we,
    output logic [MEM_AW-1:0]       tx_addr,
    output logic [DATA_WIDTH-1:0]   tx_wdata,
    output logic [DATA_WIDTH/8-1:0] tx_be,
    output logic                    rx_re,
    output logic [MEM_AW-1:0]       rx_addr,
    input  logic [DATA_WIDTH-1:0]   rx_rdata
);

    localparam int unsigned CntW = 3;

    if (RD_LATENCY < MinRdLatency || RD_LATENCY > MaxRdLatency) begin : gen_bad_latency
        $error("apb_lin_mem_bridge: RD_LATENCY must lie in 1..4");
    end
    if (REG_COUNT > (1 << MEM_AW)) begin : gen_bad_reg_count
        $error("apb_lin_mem_bridge: REG_COUNT exceeds 2**MEM_AW");
    end
    if (DATA_WIDTH % 8 != 0) begin : gen_bad_data_width
        $error("apb_lin_mem_bridge: DATA_WIDTH must be a multiple of 8");
    end

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    rd_rx_q, rd_rx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic [1:0]              region;
    logic [MEM_AW-1:0]       index;
    logic                    dec_err;

    apb_lin_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_AW     (MEM_AW),
        .REG_COUNT  (REG_COUNT)
    ) u_decode (
        .paddr  (paddr_i),
        .pwrite (pwrite_i),
        .region (region),
        .index  (index),
        .error  (dec_err)
    );

    always_ff @(posedge pclk or posedge preset_i) begin
        if (preset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_rx_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rd_rx_q <= rd_rx_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rd_rx_d   = rd_rx_q;
        rdata_d   = rdata_q;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_addr  = '0;
        reg_wdata = '0;
        reg_be    = '0;
        tx_we     = 1'b0;
        tx_addr   = '0;
        tx_wdata  = '0;
        tx_be     = '0;
        rx_re     = 1'b0;
        rx_addr   = '0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                // Strobes come straight from the access phase so read data lands in time.
                if (psel_i && penable_i && !preset_i) begin
                    err_d   = dec_err;
                    rdata_d = '0;
                    rd_rx_d = (region == RegionRx);
                    if (dec_err) begin
                        state_d = StResp;
                    end else if (pwrite_i) begin
                        state_d = StResp;
                        if (region == RegionTx) begin
                            tx_we    = 1'b1;
                            tx_addr  = index;
                            tx_wdata = pwdata_i;
                            tx_be    = pstrb_i;
                        end else begin
                            reg_we    = 1'b1;
                            reg_addr  = index;
                            reg_wdata = pwdata_i;
                            reg_be    = pstrb_i;
                        end
                    end else begin
                        state_d = StRdWait;
                        if (region == RegionRx) begin
                            rx_re   = 1'b1;
                            rx_addr = index;
                        end else begin
                            reg_re   = 1'b1;
                            reg_addr = index;
                        end
                    end
                end
            end
            StRdWait: begin
                if (!psel_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntW'(RD_LATENCY - 1)) begin
                    rdata_d = rd_rx_q ? rx_rdata : reg_rdata;
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Dropping psel in the response cycle cancels the completion.
    always_comb begin
        pready_o  = (state_q == StResp) && psel_i;
        pslverr_o = pready_o && err_q;
        prdata_o  = pready_o ? rdata_q : '0;
    end

endmodule

// File: tb/tb_apb_lin_mem_bridge.sv
// Directed bench for apb_lin_mem_bridge; four instances cover RD_LATENCY 1..4.
module tb_apb_lin_mem_bridge;

    localparam int N = 4;
    localparam logic [31:0] RxVal   = 32'hCAFE_F00D;
    localparam logic [31:0] RegVal  = 32'h1357_9BDF;
    localparam logic [31:0] JunkVal = 32'hDEAD_BEEF;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel [N];
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [11:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;

    logic [31:0] prdata [N];
    logic        pready [N];
    logic        pslverr [N];
    logic        reg_we [N];
    logic        reg_re [N];
    logic [3:0]  reg_addr [N];
    logic [31:0] reg_wdata [N];
    logic [3:0]  reg_be [N];
    logic [31:0] reg_rdata [N];
    logic        tx_we [N];
    logic [3:0]  tx_addr [N];
    logic [31:0] tx_wdata [N];
    logic [3:0]  tx_be [N];
    logic        rx_re [N];
    logic [3:0]  rx_addr [N];
    logic [31:0] rx_rdata [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pclk = ~pclk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        apb_lin_mem_bridge #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (32),
            .MEM_AW     (4),
            .REG_COUNT  (11),
            .RD_LATENCY (g + 1)
        ) u_dut (
            .pclk      (pclk),
            .preset_i  (preset),
            .psel_i    (psel[g]),
            .penable_i (penable),
            .pwrite_i  (pwrite),
            .paddr_i   (paddr),
            .pwdata_i  (pwdata),
            .pstrb_i   (pstrb),
            .prdata_o  (prdata[g]),
            .pready_o  (pready[g]),
            .pslverr_o (pslverr[g]),
            .reg_we    (reg_we[g]),
            .reg_re    (reg_re[g]),
            .reg_addr  (reg_addr[g]),
            .reg_wdata (reg_wdata[g]),
            .reg_be    (reg_be[g]),
            .reg_rdata (reg_rdata[g]),
            .tx_we     (tx_we[g]),
            .tx_addr   (tx_addr[g]),
            .tx_wdata  (tx_wdata[g]),
            .tx_be     (tx_be[g]),
            .rx_re     (rx_re[g]),
            .rx_addr   (rx_addr[g]),
            .rx_rdata  (rx_rdata[g])
        );
    end

    // Target model: read data is valid only exactly RD_LATENCY cycles after the strobe.
    int rx_age [N];
    int reg_age [N];
    always @(posedge pclk) begin
        for (int k = 0; k < N; k++) begin
            if (rx_re[k]) rx_age[k] <= 1;
            else if (rx_age[k] != 0 && rx_age[k] < 8) rx_age[k] <= rx_age[k] + 1;
            if (reg_re[k]) reg_age[k] <= 1;
            else if (reg_age[k] != 0 && reg_age[k] < 8) reg_age[k] <= reg_age[k] + 1;
        end
    end
    always_comb begin
        for (int k = 0; k < N; k++) begin
            rx_rdata[k]  = (rx_age[k] == k + 1) ? RxVal : JunkVal;
            reg_rdata[k] = (reg_age[k] == k + 1) ? RegVal : JunkVal;
        end
    end

    // Strobe monitor, sampled at the active edge like a flop would.
    int          n_reg_we [N];
    int          n_reg_re [N];
    int          n_tx_we [N];
    int          n_rx_re [N];
    logic [3:0]  last_addr [N];
    logic [3:0]  last_be [N];
    logic [31:0] last_wdata [N];
    always @(posedge pclk) begin
        for (int k = 0; k < N; k++) begin
            if (reg_we[k]) begin
                n_reg_we[k]   <= n_reg_we[k] + 1;
                last_addr[k]  <= reg_addr[k];
                last_be[k]    <= reg_be[k];
                last_wdata[k] <= reg_wdata[k];
            end
            if (tx_we[k]) begin
                n_tx_we[k]    <= n_tx_we[k] + 1;
                last_addr[k]  <= tx_addr[k];
                last_be[k]    <= tx_be[k];
                last_wdata[k] <= tx_wdata[k];
            end
            if (reg_re[k]) begin
                n_reg_re[k]  <= n_reg_re[k] + 1;
                last_addr[k] <= reg_addr[k];
            end
            if (rx_re[k]) begin
                n_rx_re[k]   <= n_rx_re[k] + 1;
                last_addr[k] <= rx_addr[k];
            end
        end
    end

    function automatic int strobes(input int k);
        return n_reg_we[k] + n_reg_re[k] + n_tx_we[k] + n_rx_re[k];
    endfunction

    function automatic logic [15:0] out_or(input int k);
        return {pready[k], pslverr[k], |prdata[k], reg_we[k], reg_re[k], |reg_addr[k],
                |reg_wdata[k], |reg_be[k], tx_we[k], |tx_addr[k], |tx_wdata[k], |tx_be[k],
                rx_re[k], |rx_addr[k], 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One APB transfer on instance k; lat counts access-phase cycles up to pready.
    task automatic xfer(input int k, input bit b2b, input logic wr, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [3:0] st,
                        output int lat, output logic [31:0] rd, output logic err);
        logic early_data;
        if (!b2b) begin
            @(posedge pclk);
            #1;
        end
        psel[k] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        pstrb   = st;
        @(posedge pclk);
        #1 penable = 1'b1;
        lat        = 0;
        rd         = '0;
        err        = 1'b0;
        early_data = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge pclk);
            if (pready[k]) begin
                lat = c;
                rd  = prdata[k];
                err = pslverr[k];
                break;
            end
            if (prdata[k] != '0 || pslverr[k]) early_data = 1'b1;
        end
        check($sformatf("idle_data_zero@%03h", addr), 32'(early_data), 32'd0);
        @(posedge pclk);
        #1;
        psel[k] = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          s0;
        int          s1;
        logic        seen;
        logic [11:0] err_addr [5];
        logic        err_wr [5];

        err_addr = '{12'h090, 12'h040, 12'h02C, 12'h0C0, 12'h001};
        err_wr   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < N; k++) psel[k] = 1'b0;

        // Reset held while a valid write access is presented.
        psel[1] = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 12'h008;
        pwdata  = 32'hFFFF_FFFF;
        pstrb   = 4'hF;
        repeat (2) @(negedge pclk);
        check("reset_outputs_l2", 32'(out_or(1)), 32'd0);
        check("reset_outputs_l4", 32'(out_or(3)), 32'd0);
        @(posedge pclk);
        #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        @(posedge pclk);
        #1 preset = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        check("reset_no_strobe", 32'(strobes(1)), 32'd0);

        // Register write.
        s0 = n_reg_we[1];
        xfer(1, 1'b0, 1'b1, 12'h008, 32'h1234_5678, 4'hF, lat, rd, err);
        check("wr_reg_latency", 32'(lat), 32'd2);
        check("wr_reg_slverr", 32'(err), 32'd0);
        check("wr_reg_prdata", rd, 32'd0);
        check("wr_reg_we_count", 32'(n_reg_we[1] - s0), 32'd1);
        check("wr_reg_addr", 32'(last_addr[1]), 32'd2);
        check("wr_reg_be", 32'(last_be[1]), 32'hF);
        check("wr_reg_wdata", last_wdata[1], 32'h1234_5678);

        // RX read.
        s0 = n_rx_re[1];
        xfer(1, 1'b0, 1'b0, 12'h084, '0, '0, lat, rd, err);
        check("rd_rx_latency", 32'(lat), 32'd4);
        check("rd_rx_data", rd, RxVal);
        check("rd_rx_slverr", 32'(err), 32'd0);
        check("rd_rx_re_count", 32'(n_rx_re[1] - s0), 32'd1);
        check("rd_rx_addr", 32'(last_addr[1]), 32'd1);

        // Error accesses: write RX, read TX, register index 11, unmapped, misaligned.
        for (int i = 0; i < 5; i++) begin
            s0 = strobes(1);
            xfer(1, 1'b0, err_wr[i], err_addr[i], 32'hFFFF_FFFF, 4'hF, lat, rd, err);
            check($sformatf("err_latency@%03h", err_addr[i]), 32'(lat), 32'd2);
            check($sformatf("err_slverr@%03h", err_addr[i]), 32'(err), 32'd1);
            check($sformatf("err_prdata@%03h", err_addr[i]), rd, 32'd0);
            check($sformatf("err_no_strobe@%03h", err_addr[i]), 32'(strobes(1) - s0), 32'd0);
        end

        // Zero byte strobes still produce a write.
        s0 = n_reg_we[1];
        xfer(1, 1'b0, 1'b1, 12'h00C, 32'h5555_AAAA, 4'h0, lat, rd, err);
        check("wr_strb0_latency", 32'(lat), 32'd2);
        check("wr_strb0_slverr", 32'(err), 32'd0);
        check("wr_strb0_we_count", 32'(n_reg_we[1] - s0), 32'd1);
        check("wr_strb0_be", 32'(last_be[1]), 32'd0);
        check("wr_strb0_addr", 32'(last_addr[1]), 32'd3);

        // TX write immediately followed by a register read.
        s0 = n_tx_we[1];
        xfer(1, 1'b0, 1'b1, 12'h044, 32'h0BAD_CAFE, 4'h3, lat, rd, err);
        check("b2b_tx_latency", 32'(lat), 32'd2);
        check("b2b_tx_we_count", 32'(n_tx_we[1] - s0), 32'd1);
        check("b2b_tx_be", 32'(last_be[1]), 32'h3);
        check("b2b_tx_addr", 32'(last_addr[1]), 32'd1);
        check("b2b_tx_wdata", last_wdata[1], 32'h0BAD_CAFE);
        s0 = n_reg_re[1];
        xfer(1, 1'b1, 1'b0, 12'h000, '0, '0, lat, rd, err);
        check("b2b_rd_latency", 32'(lat), 32'd4);
        check("b2b_rd_data", rd, RegVal);
        check("b2b_rd_re_count", 32'(n_reg_re[1] - s0), 32'd1);
        check("b2b_rd_addr", 32'(last_addr[1]), 32'd0);

        // Reset asserted during RD_WAIT.
        @(posedge pclk);
        #1;
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 12'h084;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1 preset = 1'b1;
        @(negedge pclk);
        check("rst_rdwait_outputs", 32'(out_or(1)), 32'd0);
        s1 = strobes(1);
        @(posedge pclk);
        #1;
        preset  = 1'b0;
        psel[1] = 1'b0;
        penable = 1'b0;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            if (pready[1] || out_or(1) != '0) seen = 1'b1;
        end
        check("rst_rdwait_quiet", 32'(seen), 32'd0);
        check("rst_rdwait_no_strobe", 32'(strobes(1) - s1), 32'd0);
        xfer(1, 1'b0, 1'b0, 12'h084, '0, '0, lat, rd, err);
        check("rst_recover_latency", 32'(lat), 32'd4);
        check("rst_recover_data", rd, RxVal);

        // psel dropped during RD_WAIT.
        @(posedge pclk);
        #1;
        psel[1] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 12'h084;
        @(posedge pclk);
        #1 penable = 1'b1;
        @(posedge pclk);
        #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        s1      = strobes(1);
        seen    = 1'b0;
        repeat (5) begin
            @(negedge pclk);
            if (pready[1] || out_or(1) != '0) seen = 1'b1;
        end
        check("abort_rdwait_quiet", 32'(seen), 32'd0);
        check("abort_rdwait_no_strobe", 32'(strobes(1) - s1), 32'd0);
        xfer(1, 1'b0, 1'b0, 12'h084, '0, '0, lat, rd, err);
        check("abort_recover_latency", 32'(lat), 32'd4);
        check("abort_recover_data", rd, RxVal);

        // Read latency sweep over RD_LATENCY 1..4.
        for (int k = 0; k < N; k++) begin
            s0 = n_reg_re[k];
            xfer(k, 1'b0, 1'b0, 12'h004, '0, '0, lat, rd, err);
            check($sformatf("sweep_latency_l%0d", k + 1), 32'(lat), 32'(k + 3));
            check($sformatf("sweep_data_l%0d", k + 1), rd, RegVal);
            check($sformatf("sweep_re_count_l%0d", k + 1), 32'(n_reg_re[k] - s0), 32'd1);
            check($sformatf("sweep_addr_l%0d", k + 1), 32'(last_addr[k]), 32'd1);
        end

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/apb_lin_mem_bridge.md
APB_LIN_MEM_BRIDGE -- requirements
Module: apb_lin_mem_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 12, APB address width; DATA_WIDTH 32, data width, multiple of 8; MEM_AW 4, word-address width of every target; REG_COUNT 11, implemented register words; RD_LATENCY 2, cycles from read strobe to valid target data, legal 1..4.
REQ-002 Clock/reset SHALL be one clock and one reset: pclk in 1, APB clock; preset_i in 1, reset, asynchronous and active-high.
REQ-003 APB ports SHALL be: psel_i in 1; penable_i in 1; pwrite_i in 1; paddr_i in ADDR_WIDTH; pwdata_i in DATA_WIDTH; pstrb_i in DATA_WIDTH/8, byte strobes; prdata_o out DATA_WIDTH; pready_o out 1; pslverr_o out 1.
REQ-004 Register port SHALL be: reg_we out 1; reg_re out 1; reg_addr out MEM_AW; reg_wdata out DATA_WIDTH; reg_be out DATA_WIDTH/8; reg_rdata in DATA_WIDTH.
REQ-005 TX port SHALL be: tx_we out 1; tx_addr out MEM_AW; tx_wdata out DATA_WIDTH; tx_be out DATA_WIDTH/8. RX port SHALL be: rx_re out 1; rx_addr out MEM_AW; rx_rdata in DATA_WIDTH.

Function
REQ-006 Decode SHALL use paddr_i[7:6]: 00 register, 01 TX (write-only), 10 RX (read-only), 11 unmapped; word index = paddr_i[MEM_AW+1:2].
REQ-007 An access SHALL be an error when: region unmapped; register index >= REG_COUNT; paddr_i[1:0] != 0; read of TX; write of RX.
REQ-008 FSM states SHALL be IDLE, RD_WAIT, RESP.
REQ-009 IDLE with psel_i&penable_i: valid write -> one-cycle we pulse with addr/wdata/be = pwdata_i/pstrb_i, go RESP; valid read -> one-cycle re pulse with addr, go RD_WAIT; error -> no strobe, go RESP.
REQ-010 RD_WAIT SHALL count RD_LATENCY cycles after the re pulse, then register reg_rdata or rx_rdata into prdata_o and go RESP.
REQ-011 RESP SHALL drive pready_o=1 for exactly one cycle, pslverr_o=1 only for errors, then return to IDLE.
REQ-012 Latency, first access cycle to pready_o high: write/error 2 cycles, read RD_LATENCY+2 cycles.
REQ-013 prdata_o SHALL be 0 on writes and errors and hold its read value only while pready_o=1, else 0.
REQ-014 Each strobe SHALL be a single-cycle pulse per transfer, never repeated while APB holds the access phase.
REQ-015 psel_i dropping in RD_WAIT or RESP SHALL abort to IDLE: no pready_o, no further strobes, counter cleared.
REQ-016 Back-to-back transfers SHALL be accepted starting the cycle after RESP, with no idle cycle needed.
REQ-017 pstrb_i=0 on a valid write SHALL still pulse we with be=0 and complete without error.

Reset
REQ-018 While preset_i=1, state SHALL be IDLE, counter 0, and every output 0, including all addr/wdata/be and pslverr_o.
REQ-019 Reset asserted mid-transfer SHALL drop pready_o and all strobes at once; after release the transfer is not completed and no strobe fires without a new access phase.

Structure
REQ-020 Region codes, FSM state encoding and the error-decode constants SHALL live in shared package apb_lin_pkg.
REQ-021 A sub-module apb_lin_addr_decode (combinational: region, index, error) SHALL be instantiated once; the FSM, counter and datapath stay in the top.
REQ-022 Elaboration SHALL fail if RD_LATENCY lies outside 1..4 or REG_COUNT > 2**MEM_AW.

Verification
REQ-023 Write 0x12345678, pstrb 0xF, to 0x008 -> reg_we one cycle, reg_addr 2, reg_be 0xF; pready_o 2nd cycle, pslverr_o 0.
REQ-024 Read 0x084, rx_rdata 0xCAFEF00D, RD_LATENCY 2 -> rx_re one cycle, rx_addr 1; pready_o 4th cycle with prdata_o 0xCAFEF00D.
REQ-025 Write 0x090 (RX), read 0x040 (TX), read 0x02C (index 11), access 0x0C0 -> each gives pready_o and pslverr_o 1 in cycle 2, no strobes, prdata_o 0.
REQ-026 Write 0x044, pstrb 0x3, immediately followed by read 0x000 -> tx_we with tx_be 0x3, then reg_re with no idle gap between transfers.
REQ-027 Reset asserted in RD_WAIT, and separately psel_i dropped in RD_WAIT -> no pready_o, outputs 0, next read completes normally.
REQ-028 Sweep RD_LATENCY 1..4 -> read pready_o at cycle RD_LATENCY+2; access held with pready_o low shows exactly one re pulse.
